// File: rtl/vbfs_apply.sv
// Receive/apply stage of the vbfs message stream: first-visit filtering against a local
// visited/parent store, and per-round barrier aggregation.
module vbfs_apply #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned NUM_PE = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] neighbor_in,
  input  logic [31:0] sender_in,
  input  logic [1:0]  round_in,
  input  logic        barrier_in,
  input  logic        valid_in,
  output logic        ready,
  output logic [31:0] update_sender_out,
  output logic [31:0] update_parent_out,
  output logic [1:0]  update_round_out,
  output logic        barrier_out,
  output logic        valid_out,
  input  logic        update_ack
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam int unsigned CntW  = $clog2(NUM_PE + 1);

  typedef enum logic [1:0] {StInit, StRun, StDrain} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   init_addr_q;
  logic [CntW-1:0]     barrier_cnt_q;
  logic [1:0]          round_q;

  logic                visited_q [Depth];
  logic [31:0]         parent_q  [Depth];

  logic                s1_valid_q;
  logic [31:0]         s1_neighbor_q;
  logic [31:0]         s1_sender_q;
  logic [1:0]          s1_round_q;
  logic                s1_visited_q;

  logic                out_valid_q;
  logic                out_barrier_q;
  logic [31:0]         out_sender_q;
  logic [31:0]         out_parent_q;
  logic [1:0]          out_round_q;

  logic [ADDR_W-1:0]   s1_idx;
  logic [ADDR_W-1:0]   in_idx;
  logic                s2_hit;
  logic                stall;
  logic                accept;
  logic                accept_data;
  logic                accept_bar;
  logic                s2_write;
  logic                fwd;
  logic                drain_empty;
  logic                bar_ack;

  always_comb begin
    s1_idx      = s1_neighbor_q[ADDR_W-1:0];
    in_idx      = neighbor_in[ADDR_W-1:0];
    s2_hit      = s1_valid_q & ~s1_visited_q;
    stall       = out_valid_q & ~update_ack & s2_hit;
    ready       = (state_q == StRun) & ~stall;
    accept      = valid_in & ready;
    accept_data = accept & ~barrier_in;
    accept_bar  = accept & barrier_in;
    s2_write    = s2_hit & ~stall;
    // S2 sets the bit at the same edge S1 samples it; the array read would be stale.
    fwd         = s2_write & (s1_idx == in_idx);
    drain_empty = (state_q == StDrain) & ~s1_valid_q & ~out_valid_q;
    bar_ack     = out_valid_q & out_barrier_q & update_ack;
  end

  assign valid_out         = out_valid_q;
  assign barrier_out       = out_barrier_q;
  assign update_sender_out = out_sender_q;
  assign update_parent_out = out_parent_q;
  assign update_round_out  = out_round_q;

  // Store has no reset; INIT sweeps the visited bits instead.
  always_ff @(posedge sys_clk) begin
    if (state_q == StInit) begin
      visited_q[init_addr_q] <= 1'b0;
    end else if (s2_write) begin
      visited_q[s1_idx] <= 1'b1;
      parent_q[s1_idx]  <= s1_sender_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q       <= StInit;
      init_addr_q   <= '0;
      barrier_cnt_q <= '0;
      round_q       <= 2'd0;
      s1_valid_q    <= 1'b0;
      s1_neighbor_q <= '0;
      s1_sender_q   <= '0;
      s1_round_q    <= 2'd0;
      s1_visited_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      out_barrier_q <= 1'b0;
      out_sender_q  <= '0;
      out_parent_q  <= '0;
      out_round_q   <= 2'd0;
    end else begin
      unique case (state_q)
        StInit: begin
          init_addr_q <= init_addr_q + 1'b1;
          if (init_addr_q == ADDR_W'(Depth - 1)) state_q <= StRun;
        end
        StRun: begin
          if (accept_bar) begin
            barrier_cnt_q <= barrier_cnt_q + 1'b1;
            if (barrier_cnt_q == CntW'(NUM_PE - 1)) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (bar_ack) begin
            round_q       <= round_q + 2'd1;
            barrier_cnt_q <= '0;
            state_q       <= StRun;
          end
        end
        default: state_q <= StInit;
      endcase

      if (!stall) begin
        s1_valid_q <= accept_data;
        if (accept_data) begin
          s1_neighbor_q <= neighbor_in;
          s1_sender_q   <= sender_in;
          s1_round_q    <= round_in;
          s1_visited_q  <= visited_q[in_idx] | fwd;
        end
      end

      if (s2_write) begin
        out_valid_q   <= 1'b1;
        out_barrier_q <= 1'b0;
        out_sender_q  <= s1_neighbor_q;
        out_parent_q  <= s1_sender_q;
        out_round_q   <= s1_round_q;
      end else if (drain_empty) begin
        out_valid_q   <= 1'b1;
        out_barrier_q <= 1'b1;
        out_sender_q  <= '0;
        out_parent_q  <= '0;
        out_round_q   <= round_q;
      end else if (out_valid_q && update_ack) begin
        out_valid_q   <= 1'b0;
        out_barrier_q <= 1'b0;
        out_sender_q  <= '0;
        out_parent_q  <= '0;
        out_round_q   <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_vbfs_apply.sv
// Scoreboard bench for vbfs_apply: a reference model pushes expected updates/barriers on
// acceptance, a monitor pops and compares them on each output handshake.
module tb_vbfs_apply;

  localparam int unsigned AW   = 8;
  localparam int unsigned NPE  = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [31:0] neighbor_in;
  logic [31:0] sender_in;
  logic [1:0]  round_in;
  logic        barrier_in;
  logic        valid_in;
  logic        ready;
  logic [31:0] update_sender_out;
  logic [31:0] update_parent_out;
  logic [1:0]  update_round_out;
  logic        barrier_out;
  logic        valid_out;
  logic        update_ack;

  vbfs_apply #(.ADDR_W(AW), .NUM_PE(NPE)) dut (
    .sys_clk           (sys_clk),
    .sys_rst_n         (sys_rst_n),
    .neighbor_in       (neighbor_in),
    .sender_in         (sender_in),
    .round_in          (round_in),
    .barrier_in        (barrier_in),
    .valid_in          (valid_in),
    .ready             (ready),
    .update_sender_out (update_sender_out),
    .update_parent_out (update_parent_out),
    .update_round_out  (update_round_out),
    .barrier_out       (barrier_out),
    .valid_out         (valid_out),
    .update_ack        (update_ack)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic        bar;
    logic [31:0] snd;
    logic [31:0] par;
    logic [1:0]  rnd;
  } exp_t;

  exp_t              sb_q[$];
  logic [2**AW-1:0]  m_vis;
  logic [1:0]        m_round;
  int                m_bcnt;
  int                n_cmp = 0;
  int                n_err = 0;
  bit                tx_done;
  logic [67:0]       outs;

  assign outs = {valid_out, barrier_out, update_sender_out, update_parent_out, update_round_out};

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic bar, input logic [31:0] nb, input logic [31:0] snd,
                      input logic [1:0] rnd);
    int  n;
    bit  done;
    exp_t e;
    n = 0;
    done = 1'b0;
    valid_in = 1'b1; barrier_in = bar; neighbor_in = nb; sender_in = snd; round_in = rnd;
    while (!done) begin
      @(negedge sys_clk);
      if (ready) begin
        if (bar) begin
          m_bcnt++;
          if (m_bcnt == NPE) begin
            e = '{bar: 1'b1, snd: 32'd0, par: 32'd0, rnd: m_round};
            sb_q.push_back(e);
            m_bcnt = 0;
            m_round = m_round + 2'd1;
          end
        end else if (!m_vis[nb[AW-1:0]]) begin
          m_vis[nb[AW-1:0]] = 1'b1;
          e = '{bar: 1'b0, snd: nb, par: snd, rnd: rnd};
          sb_q.push_back(e);
        end
        done = 1'b1;
      end else if (++n > 2000) begin
        check_eq("accept_timeout", 96'(ready), 96'(1));
        done = 1'b1;
      end
      @(posedge sys_clk); #1;
    end
    valid_in = 1'b0;
    barrier_in = 1'b0;
  endtask

  task automatic wait_init();
    for (int k = 0; k <= 2**AW; k++) begin
      @(negedge sys_clk);
      check_eq("init_ready", 96'(ready), 96'(k == 2**AW));
      check_eq("init_outs", 96'(outs), 96'(0));
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || valid_out) && n < 500) begin
      @(posedge sys_clk); #1;
      n++;
    end
    repeat (4) @(posedge sys_clk);
    #1;
    check_eq("drain_sb", 96'(sb_q.size()), 96'(0));
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (sys_rst_n && valid_out && update_ack) begin
      check_eq("sb_nonempty", 96'(sb_q.size() != 0), 96'(1));
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("update", 96'({barrier_out, update_sender_out, update_parent_out,
                               update_round_out}), 96'(e));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0; valid_in = 1'b0; barrier_in = 1'b0; neighbor_in = '0;
    sender_in = '0; round_in = '0; update_ack = 1'b1;
    m_vis = '0; m_round = 2'd0; m_bcnt = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    check_eq("reset_outs", 96'(outs), 96'(0));
    check_eq("reset_ready", 96'(ready), 96'(0));
    sys_rst_n = 1'b1;
    wait_init();

    // First visit, latency t+2, then a revisit that must be dropped.
    send(1'b0, 32'd5, 32'd2, 2'd0);
    @(negedge sys_clk);
    check_eq("lat_t1", 96'(valid_out), 96'(0));
    @(negedge sys_clk);
    check_eq("lat_t2", 96'(valid_out), 96'(1));
    @(posedge sys_clk); #1;
    wait_idle();
    send(1'b0, 32'd5, 32'd9, 2'd0);
    wait_idle();

    // Back-to-back duplicates exercise the forwarding path.
    send(1'b0, 32'd7, 32'd1, 2'd0);
    send(1'b0, 32'd7, 32'd3, 2'd0);
    wait_idle();

    // Backpressure: output held on 10 while 11/12 are offered.
    update_ack = 1'b0;
    tx_done = 1'b0;
    fork
      begin
        send(1'b0, 32'd10, 32'd1, 2'd0);
        send(1'b0, 32'd11, 32'd2, 2'd0);
        send(1'b0, 32'd12, 32'd3, 2'd0);
        tx_done = 1'b1;
      end
    join_none
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    check_eq("stall_ready", 96'(ready), 96'(0));
    check_eq("stall_hold", 96'({valid_out, update_sender_out}), 96'({1'b1, 32'd10}));
    @(posedge sys_clk); #1;
    update_ack = 1'b1;
    for (int n = 0; n < 200 && !tx_done; n++) begin
      @(posedge sys_clk); #1;
    end
    check_eq("stall_tx_done", 96'(tx_done), 96'(1));
    wait_idle();

    // Barrier round 0 interleaved with data, then rounds 1..3 and the wrap to 0.
    send(1'b1, 32'd0, 32'd0, 2'd0);
    send(1'b0, 32'd20, 32'd5, 2'd0);
    send(1'b1, 32'd0, 32'd0, 2'd0);
    send(1'b1, 32'd0, 32'd0, 2'd0);
    send(1'b0, 32'd21, 32'd6, 2'd0);
    send(1'b1, 32'd0, 32'd0, 2'd0);
    wait_idle();
    for (int r = 1; r <= 4; r++) begin
      for (int b = 0; b < NPE; b++) send(1'b1, 32'd0, 32'd0, 2'(r));
      wait_idle();
    end

    // Reset while draining, with an update still waiting in the output register.
    update_ack = 1'b0;
    send(1'b0, 32'd30, 32'd6, 2'd1);
    for (int b = 0; b < NPE; b++) send(1'b1, 32'd0, 32'd0, 2'd1);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_eq("drain_ready", 96'(ready), 96'(0));
    check_eq("drain_hold", 96'({valid_out, update_sender_out}), 96'({1'b1, 32'd30}));
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    check_eq("midrst_outs", 96'(outs), 96'(0));
    check_eq("midrst_ready", 96'(ready), 96'(0));
    sb_q.delete();
    m_vis = '0; m_round = 2'd0; m_bcnt = 0;
    sys_rst_n = 1'b1;
    update_ack = 1'b1;
    wait_init();
    send(1'b0, 32'd5, 32'd4, 2'd0);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
